// File: rtl/arbitri_8ne1_if.sv
// Request/grant bundle between the eight requesters and the round-robin arbiter.
// The arbiter side is the slave; the requester/CPU side is the master.
interface arbitri_8ne1_if;
  logic [7:0] kerkesa;
  logic [7:0] leje;
  logic [2:0] s;
  logic       aktiv;

  modport master (
    output kerkesa,
    input  leje,
    input  s,
    input  aktiv
  );

  modport slave (
    input  kerkesa,
    output leje,
    output s,
    output aktiv
  );
endinterface

// File: rtl/arbitri_8ne1.sv
// Round-robin arbiter for eight requesters sharing one 8:1 16-bit datapath.
// Ownership is bounded by MAX_HOLD cycles whenever another request is pending.
module arbitri_8ne1 #(
  parameter int MAX_HOLD = 4
) (
  input logic           clk,
  input logic           reset,
  arbitri_8ne1_if.slave bus
);

  typedef enum logic {IDLE, GRANT} gjendja_t;

  localparam logic [3:0] HOLD = 4'(MAX_HOLD);

  gjendja_t   gjendja_reg, gjendja_next;
  logic [2:0] pronari_reg, pronari_next;
  logic [2:0] prio_reg, prio_next;
  logic [3:0] numero_reg, numero_next;
  logic [7:0] leje_reg, leje_next;
  logic       aktiv_reg, aktiv_next;

  logic [3:0] win_idle, win_rel, win_exp;

  // Returns {found, index}: first set request scanning start, start+1, ...
  // with wrap, optionally skipping one index.
  function automatic logic [3:0] search(input logic [7:0] req, input logic [2:0] start,
                                        input logic excl_en, input logic [2:0] excl);
    logic [3:0] r;
    logic [2:0] idx;
    r = 4'd0;
    for (int j = 7; j >= 0; j--) begin
      idx = start + 3'(j);
      if (req[idx] && !(excl_en && idx == excl))
        r = {1'b1, idx};
    end
    return r;
  endfunction

  always_comb begin
    win_idle = search(bus.kerkesa, prio_reg, 1'b0, 3'd0);
    win_rel  = search(bus.kerkesa, pronari_reg + 3'd1, 1'b0, 3'd0);
    win_exp  = search(bus.kerkesa, pronari_reg + 3'd1, 1'b1, pronari_reg);
  end

  always_comb begin
    gjendja_next = gjendja_reg;
    pronari_next = pronari_reg;
    prio_next    = prio_reg;
    numero_next  = numero_reg;
    leje_next    = 8'd0;
    aktiv_next   = 1'b0;

    case (gjendja_reg)
      IDLE: begin
        if (win_idle[3]) begin
          gjendja_next = GRANT;
          pronari_next = win_idle[2:0];
          numero_next  = 4'd1;
        end
      end
      GRANT: begin
        if (!bus.kerkesa[pronari_reg]) begin
          prio_next = pronari_reg + 3'd1;
          if (win_rel[3]) begin
            pronari_next = win_rel[2:0];
            numero_next  = 4'd1;
          end else begin
            gjendja_next = IDLE;
          end
        end else if (numero_reg < HOLD) begin
          numero_next = numero_reg + 4'd1;
        end else if (win_exp[3]) begin
          pronari_next = win_exp[2:0];
          prio_next    = pronari_reg + 3'd1;
          numero_next  = 4'd1;
        end
        // otherwise the lone owner keeps the path with numero saturated
      end
      default: gjendja_next = IDLE;
    endcase

    if (gjendja_next == GRANT) begin
      leje_next  = 8'd1 << pronari_next;
      aktiv_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gjendja_reg <= IDLE;
      pronari_reg <= 3'd0;
      prio_reg    <= 3'd0;
      numero_reg  <= 4'd0;
      leje_reg    <= 8'd0;
      aktiv_reg   <= 1'b0;
    end else begin
      gjendja_reg <= gjendja_next;
      pronari_reg <= pronari_next;
      prio_reg    <= prio_next;
      numero_reg  <= numero_next;
      leje_reg    <= leje_next;
      aktiv_reg   <= aktiv_next;
    end
  end

  // The owner register only changes on a grant, so in IDLE it holds the last select.
  assign bus.leje  = leje_reg;
  assign bus.s     = pronari_reg;
  assign bus.aktiv = aktiv_reg;

endmodule

// File: doc/arbitri_8ne1.md
# arbitri_8ne1

Round-robin arbiter that shares one 8-to-1 selected 16-bit datapath source among eight requesters. It decides each cycle which requester owns the shared path and drives the 3-bit select of the 8:1 multiplexer, so exactly one source reaches the shared CPU bus at a time. Each requester also receives a one-hot grant. Ownership is held while requested, but is bounded by a hold limit so that no requester can starve the others.

## Interface
- `MAX_HOLD`, default 4: the maximum number of consecutive cycles one owner keeps the grant while another request is pending. Legal range is 1..15.
- `clk`  input  1  the single clock. All state changes on its rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `kerkesa`  input  8  request vector. Bit i is the request of requester i and is held high for as long as requester i wants the path.
- `leje`  output  8  registered one-hot grant. All zero when the path is idle.
- `s`  output  3  registered select for the 8:1 mux. Equals the index of the current owner.
- `aktiv`  output  1  registered flag. High exactly when `leje` is nonzero.

## Operation
- State: `GJENDJA` ∈ {IDLE, GRANT}, owner index `pronari`[2:0], priority pointer `prio`[2:0], hold counter `numero`[3:0].
- Reset values, applied immediately while `reset`=1:
  - IDLE, `leje`=0, `s`=0, `aktiv`=0.
  - `prio`=0, `numero`=0.
- Circular search from a start index k:
  - Scan k, k+1, … up to 7, then wrap to 0, for the first bit of `kerkesa` that is high.
  - An optional excluded index is skipped.
- IDLE:
  - If `kerkesa`=0, stay in IDLE. Outputs are unchanged and `s` keeps its last value.
  - Otherwise, go to GRANT. The owner is the result of the search from `prio`. `numero` is set to 1.
- GRANT, with owner i:
  - Release, when `kerkesa[i]`=0:
    - `prio` is set to (i+1) mod 8.
    - If any other request is high, grant directly to the winner of the search from (i+1) mod 8, with `numero`=1 and no idle gap.
    - Otherwise, go to IDLE with `leje`=0 and `aktiv`=0.
  - Hold, when `kerkesa[i]`=1 and `numero` < `MAX_HOLD`: keep the owner and increment `numero`.
  - Expiry, when `kerkesa[i]`=1 and `numero`=`MAX_HOLD`:
    - If any request other than i is high, switch to the winner of the search from (i+1) mod 8 that excludes i. Set `prio`=(i+1) mod 8 and `numero`=1.
    - Otherwise, keep the owner and saturate `numero` at `MAX_HOLD`. The switch then happens on the first cycle another request appears.
- Invariants:
  - `leje` is zero or one-hot.
  - `s` equals the index of the set bit of `leje` whenever `aktiv`=1.
  - `aktiv` equals the OR of all bits of `leje`.
- `numero` arithmetic is 4-bit unsigned and never wraps.
- A request deasserted by a non-owner has no effect.

## Timing
- All outputs come from registers. There is no combinational path from `kerkesa` to `leje`, `s` or `aktiv`.
- Grant latency: a request sampled at rising edge t appears on `leje`, `s` and `aktiv` immediately after edge t, provided the path is idle or is released at t.
- Owner-to-owner handover completes in one edge, with no idle cycle.
- The maximum wait for a continuously asserted request is 7×`MAX_HOLD` cycles after it is first sampled.
- Simultaneous release by the owner and new requests: the handover is evaluated in the same edge. The rule is release-then-search from (i+1) mod 8.
- Reset asserted mid-grant: `leje`, `aktiv` and `s` clear asynchronously without waiting for a clock edge. After reset deasserts, arbitration restarts from `prio`=0 at the first edge.

## Test plan
- Reset, then idle:
  - Stimulus: `reset`=1, then 0, with `kerkesa`=0 for 5 cycles.
  - Required response: `leje`=0, `s`=0 and `aktiv`=0 throughout.
- Single requester:
  - Stimulus: `kerkesa`=8'h20 for 3 cycles, then 0.
  - Required response: after the first edge, `leje`=8'h20, `s`=5 and `aktiv`=1 for 3 cycles. `aktiv` is 0 one edge after release.
- Round-robin and wrap:
  - Stimulus: `MAX_HOLD`=2, `kerkesa`=8'h81 held constant.
  - Required response: the owner sequence is 0,0,7,7,0,0,7,7… and `s` follows 0,0,7,7…
- Release handover:
  - Stimulus: owner 3 holds while `kerkesa`=8'h48. Then bit 3 drops, leaving `kerkesa`=8'h40.
  - Required response: on the next edge, `leje`=8'h40 and `s`=6, with no cycle in which `aktiv`=0.
- Saturated hold:
  - Stimulus: `MAX_HOLD`=4, owner 2 alone for 10 cycles, then bit 1 rises.
  - Required response: owner 2 is kept for all 10 cycles. On the edge after bit 1 rises, `leje`=8'h02 and `s`=1.
- Async reset mid-grant:
  - Stimulus: with `leje`=8'h10, pulse `reset` between clock edges.
  - Required response: `leje`=0, `s`=0 and `aktiv`=0 before the next edge. With `kerkesa`=8'hFF afterwards, the first grant goes to 0.
